// File: rtl/rv32_dmem_responder_if.sv
// Data-port bundle between the rv32e_cpu data master and the data-memory responder.
// The CPU drives the request side; the responder drives read data, ready and error.
interface rv32_dmem_responder_if;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_data_out;
    logic        dmem_read;
    logic        dmem_write;
    logic [3:0]  dmem_byte_enable;
    logic [31:0] dmem_data_in;
    logic        dmem_ready;
    logic        dmem_error;

    modport master (
        output dmem_addr, dmem_data_out, dmem_read, dmem_write, dmem_byte_enable,
        input  dmem_data_in, dmem_ready, dmem_error
    );

    modport slave (
        input  dmem_addr, dmem_data_out, dmem_read, dmem_write, dmem_byte_enable,
        output dmem_data_in, dmem_ready, dmem_error
    );
endinterface

// File: rtl/rv32_dmem_responder.sv
// Wait-stated data-memory responder for the rv32e_cpu data port, backed by word-addressed storage.
// Optional response statistics counters are enabled with `define DMEM_RESP_STATS_EN.
module rv32_dmem_responder #(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input logic                  clk,
    input logic                  reset,
    rv32_dmem_responder_if.slave dmem
`ifdef DMEM_RESP_STATS_EN
    ,
    output logic [31:0]          stat_reads,
    output logic [31:0]          stat_writes,
    output logic [15:0]          stat_errors
`endif
);

    localparam int          DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [32:0] SPAN      = 33'd4 << ADDR_WIDTH;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Only single bytes, aligned halfwords and full words are legal write shapes.
    function automatic logic be_legal(input logic [3:0] be);
        logic ok;
        case (be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: ok = 1'b1;
            default:                   ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_t                  state_r, state_next_s;
    logic [3:0]              cnt_r, cnt_next_s;
    logic                    accept_s;
    logic [31:0]             off_s;
    logic                    in_err_s;

    logic [ADDR_WIDTH-1:0]   idx_r;
    logic [31:0]             wdata_r;
    logic [3:0]              be_r;
    logic                    rd_r, wr_r, err_r;

    logic [ADDR_WIDTH-1:0]   cur_idx_s;
    logic [31:0]             cur_wdata_s;
    logic [3:0]              cur_be_s;
    logic                    cur_rd_s, cur_wr_s, cur_err_s;
    logic                    enter_resp_s;
    logic                    mem_we_s;

    logic [31:0]             mem_r [0:DEPTH-1];
    logic [31:0]             data_in_r;
    logic                    ready_r;
    logic                    error_r;

    assign off_s    = dmem.dmem_addr - BASE_ADDR;
    assign in_err_s = (dmem.dmem_read & dmem.dmem_write)
                    | ({1'b0, off_s} >= SPAN)
                    | (dmem.dmem_write & ~be_legal(dmem.dmem_byte_enable));

    // Next-state and wait-counter logic.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        accept_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (dmem.dmem_read | dmem.dmem_write) begin
                    accept_s = 1'b1;
                    if (WAIT_STATES > 0) begin
                        state_next_s = ST_WAIT;
                        cnt_next_s   = WAIT_LOAD;
                    end else begin
                        state_next_s = ST_RESP;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_next_s = ST_RESP;
                end else begin
                    cnt_next_s = cnt_r - 4'd1;
                end
            end
            ST_RESP: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // With zero wait states RESP is entered on the accept edge, so the live request is used then.
    always_comb begin
        cur_idx_s   = idx_r;
        cur_wdata_s = wdata_r;
        cur_be_s    = be_r;
        cur_rd_s    = rd_r;
        cur_wr_s    = wr_r;
        cur_err_s   = err_r;
        if (state_r == ST_IDLE) begin
            cur_idx_s   = off_s[ADDR_WIDTH+1:2];
            cur_wdata_s = dmem.dmem_data_out;
            cur_be_s    = dmem.dmem_byte_enable;
            cur_rd_s    = dmem.dmem_read;
            cur_wr_s    = dmem.dmem_write;
            cur_err_s   = in_err_s;
        end else begin
            cur_idx_s   = idx_r;
        end
    end

    assign enter_resp_s = (state_next_s == ST_RESP);
    assign mem_we_s     = reset & enter_resp_s & cur_wr_s & ~cur_err_s;

    // FSM state and wait counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Request capture on accept; inputs are ignored until the next IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_r   <= '0;
            wdata_r <= 32'd0;
            be_r    <= 4'd0;
            rd_r    <= 1'b0;
            wr_r    <= 1'b0;
            err_r   <= 1'b0;
        end else if (accept_s) begin
            idx_r   <= off_s[ADDR_WIDTH+1:2];
            wdata_r <= dmem.dmem_data_out;
            be_r    <= dmem.dmem_byte_enable;
            rd_r    <= dmem.dmem_read;
            wr_r    <= dmem.dmem_write;
            err_r   <= in_err_s;
        end
    end

    // Storage write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_be_s[i]) begin
                    mem_r[cur_idx_s][8*i +: 8] <= cur_wdata_s[8*i +: 8];
                end
            end
        end
    end

    // Registered response: ready/error for the RESP cycle, read data held until the next read or error.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_in_r <= 32'd0;
            ready_r   <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            ready_r <= enter_resp_s;
            error_r <= enter_resp_s & cur_err_s;
            if (enter_resp_s && cur_err_s) begin
                data_in_r <= 32'd0;
            end else if (enter_resp_s && cur_rd_s) begin
                data_in_r <= mem_r[cur_idx_s];
            end else begin
                data_in_r <= data_in_r;
            end
        end
    end

    assign dmem.dmem_data_in = data_in_r;
    assign dmem.dmem_ready   = ready_r;
    assign dmem.dmem_error   = error_r;

`ifdef DMEM_RESP_STATS_EN
    logic [31:0] stat_reads_r;
    logic [31:0] stat_writes_r;
    logic [15:0] stat_errors_r;

    // Saturating response counters, bumped on the edge leaving RESP.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_reads_r  <= 32'd0;
            stat_writes_r <= 32'd0;
            stat_errors_r <= 16'd0;
        end else if (state_r == ST_RESP) begin
            if (err_r) begin
                if (stat_errors_r != 16'hFFFF) stat_errors_r <= stat_errors_r + 16'd1;
            end else if (rd_r) begin
                if (stat_reads_r != 32'hFFFF_FFFF) stat_reads_r <= stat_reads_r + 32'd1;
            end else if (wr_r) begin
                if (stat_writes_r != 32'hFFFF_FFFF) stat_writes_r <= stat_writes_r + 32'd1;
            end
        end
    end

    assign stat_reads  = stat_reads_r;
    assign stat_writes = stat_writes_r;
    assign stat_errors = stat_errors_r;
`endif

endmodule

// File: tb/tb_rv32_dmem_responder.sv
// Randomized and directed bench for rv32_dmem_responder: three instances (0, 1 and 3 wait states)
// checked against a word-array memory model and the response timing rules.
module tb_rv32_dmem_responder;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          WORDS = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] b_addr, b_wdata;
    logic        b_rd, b_wr;
    logic [3:0]  b_be;
    int          sel;

    int          vec_cnt = 0;
    int          miss_cnt = 0;
    int          ws_of [3] = '{0, 1, 3};
    logic [3:0]  legal_be [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

    logic [31:0] mdl_mem  [3][WORDS];
    bit          mdl_vld  [3][WORDS];
    logic [31:0] mdl_last [3];
    int          n_rd [3];
    int          n_wr [3];
    int          n_er [3];

    always #5 clk = ~clk;

    rv32_dmem_responder_if if0 ();
    rv32_dmem_responder_if if1 ();
    rv32_dmem_responder_if if2 ();

    assign if0.dmem_addr = b_addr;  assign if0.dmem_data_out = b_wdata;  assign if0.dmem_byte_enable = b_be;
    assign if1.dmem_addr = b_addr;  assign if1.dmem_data_out = b_wdata;  assign if1.dmem_byte_enable = b_be;
    assign if2.dmem_addr = b_addr;  assign if2.dmem_data_out = b_wdata;  assign if2.dmem_byte_enable = b_be;
    assign if0.dmem_read = b_rd & (sel == 0);  assign if0.dmem_write = b_wr & (sel == 0);
    assign if1.dmem_read = b_rd & (sel == 1);  assign if1.dmem_write = b_wr & (sel == 1);
    assign if2.dmem_read = b_rd & (sel == 2);  assign if2.dmem_write = b_wr & (sel == 2);

    logic        rdy  [3];
    logic        erro [3];
    logic [31:0] dat  [3];
    assign rdy[0] = if0.dmem_ready;  assign erro[0] = if0.dmem_error;  assign dat[0] = if0.dmem_data_in;
    assign rdy[1] = if1.dmem_ready;  assign erro[1] = if1.dmem_error;  assign dat[1] = if1.dmem_data_in;
    assign rdy[2] = if2.dmem_ready;  assign erro[2] = if2.dmem_error;  assign dat[2] = if2.dmem_data_in;

`ifdef DMEM_RESP_STATS_EN
    logic [31:0] sr [3];
    logic [31:0] sw [3];
    logic [15:0] se [3];
    rv32_dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0), .BASE_ADDR(BASE)) u0 (
        .clk(clk), .reset(reset), .dmem(if0), .stat_reads(sr[0]), .stat_writes(sw[0]), .stat_errors(se[0]));
    rv32_dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1), .BASE_ADDR(BASE)) u1 (
        .clk(clk), .reset(reset), .dmem(if1), .stat_reads(sr[1]), .stat_writes(sw[1]), .stat_errors(se[1]));
    rv32_dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3), .BASE_ADDR(BASE)) u2 (
        .clk(clk), .reset(reset), .dmem(if2), .stat_reads(sr[2]), .stat_writes(sw[2]), .stat_errors(se[2]));
`else
    rv32_dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0), .BASE_ADDR(BASE)) u0 (
        .clk(clk), .reset(reset), .dmem(if0));
    rv32_dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1), .BASE_ADDR(BASE)) u1 (
        .clk(clk), .reset(reset), .dmem(if1));
    rv32_dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3), .BASE_ADDR(BASE)) u2 (
        .clk(clk), .reset(reset), .dmem(if2));
`endif

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_legal_be(input logic [3:0] be);
        bit ok = 1'b0;
        for (int i = 0; i < 7; i++) if (legal_be[i] == be) ok = 1'b1;
        return ok;
    endfunction

    function automatic void clear_model_outputs();
        for (int k = 0; k < 3; k++) begin
            mdl_last[k] = 32'd0;
            n_rd[k] = 0;
            n_wr[k] = 0;
            n_er[k] = 0;
        end
    endfunction

    // One full transaction on instance k, checking latency, error, data and single-cycle ready.
    task automatic do_req(input int k, input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] off;
        logic [31:0] mask;
        bit          e;
        int          widx;
        int          n;
        off  = addr - BASE;
        e    = (rd && wr) || (off >= 32'd4096) || (wr && !is_legal_be(be));
        widx = int'(off[11:2]);
        @(negedge clk);
        sel = k; b_addr = addr; b_wdata = wd; b_rd = rd; b_wr = wr; b_be = be;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                b_rd = 1'b0; b_wr = 1'b0;
                b_addr = $urandom; b_wdata = $urandom; b_be = 4'($urandom);
            end
        end while (!rdy[k] && n < 20);
        if (e) begin
            mdl_last[k] = 32'd0;
            n_er[k]++;
        end else if (rd) begin
            mdl_last[k] = mdl_mem[k][widx];
            n_rd[k]++;
        end else begin
            mask = 32'd0;
            for (int i = 0; i < 4; i++) if (be[i]) mask[8*i +: 8] = 8'hFF;
            mdl_mem[k][widx] = (mdl_mem[k][widx] & ~mask) | (wd & mask);
            mdl_vld[k][widx] = 1'b1;
            n_wr[k]++;
        end
        check_val("latency", n, ws_of[k] + 1);
        check_val("error", {31'd0, erro[k]}, {31'd0, e});
        check_val("data", dat[k], mdl_last[k]);
        @(posedge clk); #1;
        check_val("pulse", {31'd0, rdy[k]}, 32'd0);
    endtask

    initial begin
        int          seen;
        int          choice;
        int          widx;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [3:0]  hold_pat;

        reset = 1'b0; sel = 0; b_addr = 32'd0; b_wdata = 32'd0; b_rd = 1'b0; b_wr = 1'b0; b_be = 4'd0;
        clear_model_outputs();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check_val("rst_ready", {31'd0, rdy[k]}, 32'd0);
            check_val("rst_error", {31'd0, erro[k]}, 32'd0);
            check_val("rst_data", dat[k], 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;

        // Full-word write/read with one wait state, plus ignored low address bits.
        do_req(1, 1'b0, 1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'b1111);
        do_req(1, 1'b1, 1'b0, BASE + 32'h10, 32'd0, 4'b0000);
        check_val("full_word", dat[1], 32'hDEADBEEF);
        do_req(1, 1'b1, 1'b0, BASE + 32'h13, 32'd0, 4'b0101);
        check_val("low_bits", dat[1], 32'hDEADBEEF);

        // Partial-lane merges.
        do_req(1, 1'b0, 1'b1, BASE + 32'h20, 32'h11223344, 4'b1111);
        do_req(1, 1'b0, 1'b1, BASE + 32'h20, 32'h00AA0000, 4'b0100);
        do_req(1, 1'b1, 1'b0, BASE + 32'h20, 32'd0, 4'b0000);
        check_val("part_b2", dat[1], 32'h11AA3344);
        do_req(1, 1'b0, 1'b1, BASE + 32'h20, 32'hBBCC0000, 4'b1100);
        do_req(1, 1'b1, 1'b0, BASE + 32'h20, 32'd0, 4'b0000);
        check_val("part_hi", dat[1], 32'hBBCC3344);

        // Error cases and address boundaries.
        do_req(1, 1'b1, 1'b0, BASE + 32'h1000, 32'd0, 4'b0000);
        do_req(1, 1'b0, 1'b1, BASE + 32'h20, 32'h55555555, 4'b0101);
        do_req(1, 1'b1, 1'b0, BASE + 32'h20, 32'd0, 4'b0000);
        check_val("bad_be_keep", dat[1], 32'hBBCC3344);
        do_req(1, 1'b1, 1'b1, BASE + 32'h20, 32'h0, 4'b1111);
        do_req(1, 1'b1, 1'b0, BASE - 32'd4, 32'd0, 4'b0000);
        do_req(1, 1'b0, 1'b1, BASE + 32'hFFC, 32'hA5A5C3C3, 4'b1111);
        do_req(1, 1'b1, 1'b0, BASE + 32'hFFC, 32'd0, 4'b0000);
        check_val("top_word", dat[1], 32'hA5A5C3C3);

        // Zero wait states with a read held high across two responses.
        do_req(0, 1'b0, 1'b1, BASE + 32'h8, 32'h0BADF00D, 4'b1111);
        @(negedge clk);
        sel = 0; b_addr = BASE + 32'h8; b_rd = 1'b1; b_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            hold_pat[i] = rdy[0];
            if (i == 0 || i == 2) check_val("hold_data", dat[0], 32'h0BADF00D);
        end
        b_rd = 1'b0;
        check_val("hold_pattern", {28'd0, hold_pat}, 32'h0000_0005);
        n_rd[0] += 2;
        mdl_last[0] = 32'h0BADF00D;
        @(posedge clk); #1;

        // Reset while a 3-wait-state write is still counting down.
        do_req(2, 1'b0, 1'b1, BASE + 32'h40, 32'h01020304, 4'b1111);
        @(negedge clk);
        sel = 2; b_addr = BASE + 32'h40; b_wdata = 32'hFFEEDDCC; b_be = 4'b1111; b_wr = 1'b1;
        @(posedge clk); #1;
        b_wr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        clear_model_outputs();
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (rdy[2]) seen = 1;
        end
        check_val("abort_ready", seen, 0);
        do_req(2, 1'b1, 1'b0, BASE + 32'h40, 32'd0, 4'b0000);
        check_val("abort_old", dat[2], 32'h01020304);

        // Randomized mix of legal, illegal and out-of-range traffic on every instance.
        for (int k = 0; k < 3; k++) begin
            for (int t = 0; t < 40; t++) begin
                choice = $urandom_range(0, 9);
                widx = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : 1016 + $urandom_range(0, 7);
                addr = BASE + 32'(widx * 4) + 32'($urandom_range(0, 3));
                if (choice >= 4 && choice <= 6 && !mdl_vld[k][widx]) choice = 0;
                if (choice <= 3) begin
                    do_req(k, 1'b0, 1'b1, addr, $urandom, legal_be[$urandom_range(0, 6)]);
                end else if (choice <= 6) begin
                    do_req(k, 1'b1, 1'b0, addr, $urandom, 4'($urandom));
                end else if (choice == 7) begin
                    be = 4'($urandom);
                    while (is_legal_be(be)) be = 4'($urandom);
                    do_req(k, 1'b0, 1'b1, addr, $urandom, be);
                end else if (choice == 8) begin
                    do_req(k, 1'b1, 1'b1, addr, $urandom, 4'b1111);
                end else if ($urandom_range(0, 1) == 1) begin
                    do_req(k, 1'b1, 1'b0, BASE + 32'h1000 + 32'($urandom_range(0, 4095)), 32'd0, 4'd0);
                end else begin
                    do_req(k, 1'b1, 1'b0, BASE - 32'd1 - 32'($urandom_range(0, 4095)), 32'd0, 4'd0);
                end
            end
        end

`ifdef DMEM_RESP_STATS_EN
        for (int k = 0; k < 3; k++) begin
            check_val("stat_reads", sr[k], n_rd[k]);
            check_val("stat_writes", sw[k], n_wr[k]);
            check_val("stat_errors", {16'd0, se[k]}, n_er[k]);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check_val("stat_clear", sr[k] | sw[k] | {16'd0, se[k]}, 32'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
